// File: rtl/ula_seq_if.sv
// Request/result bundle between instruction decode and the ula_seq arithmetic unit.
interface ula_seq_if #(
  parameter int LARGURA = 16
);
  logic                      inicio;
  logic [2:0]                opcode;
  logic signed [LARGURA-1:0] valor1;
  logic signed [LARGURA-1:0] valor2;
  logic                      pronto;
  logic                      executou;
  logic signed [LARGURA-1:0] resultado;
  logic                      erro;
  logic                      flag_zero;
  logic                      flag_neg;
  logic                      flag_ovf;

  modport master (
    output inicio, opcode, valor1, valor2,
    input  pronto, executou, resultado, erro, flag_zero, flag_neg, flag_ovf
  );

  modport slave (
    input  inicio, opcode, valor1, valor2,
    output pronto, executou, resultado, erro, flag_zero, flag_neg, flag_ovf
  );
endinterface

// File: rtl/ula_seq.sv
// ula_seq: registered arithmetic unit (load/add/sub, optional multiply) behind a valid/ready handshake.
// Define ULA_MUL_EN to build the iterative shift-add multiplier for opcode 101.
module ula_seq #(
  parameter int LARGURA = 16
) (
  input logic      clk,
  input logic      rst_n,
  ula_seq_if.slave bus
);
  // state      | meaning
  // OCIOSO     | idle; one request accepted per cycle, non-mul completes one edge later
  // MULTIPLICA | shift-add running; counter==0 is the write-back cycle (already ready again)
  typedef enum logic {OCIOSO, MULTIPLICA} estado_t;

  localparam int M  = LARGURA - 1;
  localparam int CW = $clog2(LARGURA + 1);

  estado_t            estado_q, estado_d;
  logic               pronto_q, pronto_d;
  logic               executou_q, executou_d;
  logic               erro_q, erro_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic [LARGURA-1:0] resultado_q, resultado_d;
  logic               pend_q, pend_d;
  logic [2:0]         op_q, op_d;
  logic [LARGURA-1:0] a_q, a_d;
  logic [LARGURA-1:0] b_q, b_d;
  logic [LARGURA-1:0] soma, dif;
  logic               aceita;
`ifdef ULA_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b101;
  logic [LARGURA-1:0] acc_q, acc_d;
  logic [CW-1:0]      cont_q, cont_d;
`endif

  assign aceita = bus.inicio && pronto_q;
  assign soma   = a_q + b_q;
  assign dif    = a_q - b_q;
  assign zero_d = (resultado_d == '0);
  assign neg_d  = resultado_d[M];

  always_comb begin
    estado_d    = estado_q;
    pronto_d    = pronto_q;
    executou_d  = 1'b0;
    resultado_d = resultado_q;
    erro_d      = erro_q;
    ovf_d       = ovf_q;
    pend_d      = 1'b0;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
`ifdef ULA_MUL_EN
    acc_d       = acc_q;
    cont_d      = cont_q;
`endif

    // a_q/b_q double as multiplicand/multiplier while a multiply is running
    if (pend_q) begin
      executou_d = 1'b1;
      erro_d     = 1'b0;
      ovf_d      = 1'b0;
      case (op_q)
        3'b000: resultado_d = b_q;
        3'b001, 3'b010: begin
          resultado_d = soma;
          ovf_d       = (a_q[M] == b_q[M]) && (soma[M] != a_q[M]);
        end
        3'b011, 3'b100: begin
          resultado_d = dif;
          ovf_d       = (a_q[M] != b_q[M]) && (dif[M] != a_q[M]);
        end
        default: begin
          resultado_d = '0;
          erro_d      = 1'b1;
        end
      endcase
    end

`ifdef ULA_MUL_EN
    if (estado_q == MULTIPLICA) begin
      if (cont_q != '0) begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d      = a_q << 1;
        b_d      = b_q >> 1;
        cont_d   = cont_q - CW'(1);
        pronto_d = (cont_q == CW'(1));
      end else begin
        resultado_d = acc_q;
        executou_d  = 1'b1;
        erro_d      = 1'b0;
        ovf_d       = 1'b0;
        estado_d    = OCIOSO;
      end
    end
`endif

    if (aceita) begin
`ifdef ULA_MUL_EN
      if (bus.opcode == OP_MUL) begin
        a_d      = bus.valor1;
        b_d      = bus.valor2;
        acc_d    = '0;
        cont_d   = CW'(LARGURA);
        estado_d = MULTIPLICA;
        pronto_d = 1'b0;
      end else
`endif
      begin
        pend_d = 1'b1;
        op_d   = bus.opcode;
        a_d    = bus.valor1;
        b_d    = bus.valor2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= OCIOSO;
      pronto_q    <= 1'b1;
      executou_q  <= 1'b0;
      erro_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b1;
      neg_q       <= 1'b0;
      resultado_q <= '0;
      pend_q      <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
`ifdef ULA_MUL_EN
      acc_q       <= '0;
      cont_q      <= '0;
`endif
    end else begin
      estado_q    <= estado_d;
      pronto_q    <= pronto_d;
      executou_q  <= executou_d;
      erro_q      <= erro_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      resultado_q <= resultado_d;
      pend_q      <= pend_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
`ifdef ULA_MUL_EN
      acc_q       <= acc_d;
      cont_q      <= cont_d;
`endif
    end
  end

  assign bus.pronto    = pronto_q;
  assign bus.executou  = executou_q;
  assign bus.resultado = resultado_q;
  assign bus.erro      = erro_q;
  assign bus.flag_zero = zero_q;
  assign bus.flag_neg  = neg_q;
  assign bus.flag_ovf  = ovf_q;
endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq: latency/queue reference model, per-cycle compare, directed literal checks.
module tb_ula_seq;
  localparam int L = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ula_seq_if #(.LARGURA(L)) bus ();
  ula_seq #(.LARGURA(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nome, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nome, got, exp, $time);
    end
  endtask

  // Reference: each accepted request becomes a completion due at a fixed future edge.
  typedef struct {
    int          due;
    logic [15:0] r;
    logic        e;
    logic        o;
  } done_t;

  done_t       fila[$];
  done_t       nd;
  bit          nd_mul;
  int          cyc = 0;
  int          mul_end = 0;
  logic        m_pronto = 1'b1;
  logic        m_exec = 1'b0;
  logic        m_erro = 1'b0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_res = '0;

  function automatic void ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic e, output logic o, output bit mul);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = '0; e = 1'b0; o = 1'b0; mul = 1'b0;
    case (op)
      3'd0: r = b;
      3'd1, 3'd2: begin s = sa + sb; r = 16'(s); o = (s > 32767) || (s < -32768); end
      3'd3, 3'd4: begin s = sa - sb; r = 16'(s); o = (s > 32767) || (s < -32768); end
`ifdef ULA_MUL_EN
      3'd5: begin s = sa * sb; r = 16'(s); mul = 1'b1; end
`endif
      default: e = 1'b1;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fila.delete();
      m_pronto = 1'b1; m_exec = 1'b0; m_erro = 1'b0; m_ovf = 1'b0; m_res = '0;
      mul_end = 0;
    end else begin
      cyc++;
      m_exec = 1'b0;
      if (fila.size() > 0 && fila[0].due == cyc) begin
        nd = fila.pop_front();
        m_res = nd.r; m_erro = nd.e; m_ovf = nd.o; m_exec = 1'b1;
      end
      if (bus.inicio && m_pronto) begin
        ref_op(bus.opcode, bus.valor1, bus.valor2, nd.r, nd.e, nd.o, nd_mul);
        nd.due = cyc + (nd_mul ? L + 1 : 1);
        if (nd_mul) mul_end = cyc + L;
        fila.push_back(nd);
      end
      m_pronto = (cyc >= mul_end);
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("cmp_pronto", bus.pronto, m_pronto);
      chk("cmp_executou", bus.executou, m_exec);
      chk("cmp_resultado", bus.resultado, m_res);
      chk("cmp_erro", bus.erro, m_erro);
      chk("cmp_zero", bus.flag_zero, m_res == 16'h0);
      chk("cmp_neg", bus.flag_neg, m_res[15]);
      chk("cmp_ovf", bus.flag_ovf, m_ovf);
    end
  end

  task automatic drv(input bit ini, input bit [2:0] op, input bit [15:0] a, input bit [15:0] b);
    bus.inicio = ini; bus.opcode = op; bus.valor1 = a; bus.valor2 = b;
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pronto"}, bus.pronto, 1'b1);
    chk({tag, "_executou"}, bus.executou, 1'b0);
    chk({tag, "_erro"}, bus.erro, 1'b0);
    chk({tag, "_resultado"}, bus.resultado, 16'h0000);
    chk({tag, "_zero"}, bus.flag_zero, 1'b1);
    chk({tag, "_neg"}, bus.flag_neg, 1'b0);
    chk({tag, "_ovf"}, bus.flag_ovf, 1'b0);
  endtask

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    bus.inicio = 1'b0; bus.opcode = '0; bus.valor1 = '0; bus.valor2 = '0;
    repeat (3) @(negedge clk);
    chk_reset("rst_init");
    rst_n = 1'b1;
    drv(0, 0, 0, 0);
    chk("rel_pronto", bus.pronto, 1'b1);

    // 0x7FFF + 1: signed overflow into 0x8000
    drv(1, 3'b001, 16'h7FFF, 16'h0001);
    chk("add_lat_exec", bus.executou, 1'b0);
    drv(0, 0, 0, 0);
    chk("add_exec", bus.executou, 1'b1);
    chk("add_res", bus.resultado, 16'h8000);
    chk("add_neg", bus.flag_neg, 1'b1);
    chk("add_ovf", bus.flag_ovf, 1'b1);
    chk("add_erro", bus.erro, 1'b0);
    chk("model_add", m_res, 16'h8000);

    // load then 5-5 back-to-back
    drv(1, 3'b000, 16'hAAAA, 16'h1234);
    drv(1, 3'b011, 16'h0005, 16'h0005);
    chk("ld_exec", bus.executou, 1'b1);
    chk("ld_res", bus.resultado, 16'h1234);
    drv(0, 0, 0, 0);
    chk("sub_exec", bus.executou, 1'b1);
    chk("sub_res", bus.resultado, 16'h0000);
    chk("sub_zero", bus.flag_zero, 1'b1);
    chk("sub_ovf", bus.flag_ovf, 1'b0);
    drv(0, 0, 0, 0);
    chk("sub_pulse_end", bus.executou, 1'b0);

    // illegal opcode 111
    drv(1, 3'b111, 16'h1111, 16'h2222);
    drv(0, 0, 0, 0);
    chk("ill_exec", bus.executou, 1'b1);
    chk("ill_erro", bus.erro, 1'b1);
    chk("ill_res", bus.resultado, 16'h0000);
    chk("ill_zero", bus.flag_zero, 1'b1);
    chk("model_ill", {15'h0, m_erro}, 16'h0001);

`ifdef ULA_MUL_EN
    // -3 x 7 with an ignored request inside the busy window
    drv(1, 3'b101, 16'hFFFD, 16'h0007);
    for (int i = 0; i < 16; i++) begin
      chk("mul_busy", bus.pronto, 1'b0);
      drv(i == 4, 3'b001, 16'h0009, 16'h0009);
    end
    chk("mul_ready", bus.pronto, 1'b1);
    chk("mul_not_yet", bus.executou, 1'b0);
    drv(0, 0, 0, 0);
    chk("mul_exec", bus.executou, 1'b1);
    chk("mul_res", bus.resultado, 16'hFFEB);
    chk("mul_neg", bus.flag_neg, 1'b1);
    chk("model_mul", m_res, 16'hFFEB);
    drv(0, 0, 0, 0);
    chk("mul_ignored", bus.executou, 1'b0);

    // 0x0100 x 0x0100 truncates to zero
    drv(1, 3'b101, 16'h0100, 16'h0100);
    repeat (17) drv(0, 0, 0, 0);
    chk("mul0_exec", bus.executou, 1'b1);
    chk("mul0_res", bus.resultado, 16'h0000);
    chk("mul0_zero", bus.flag_zero, 1'b1);

    // reset five cycles into a multiply
    drv(1, 3'b101, 16'h0003, 16'h0004);
    repeat (4) drv(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_mul");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drv(0, 0, 0, 0);
      chk("abort_no_exec", bus.executou, 1'b0);
    end
    chk("abort_res", bus.resultado, 16'h0000);
    chk("abort_pronto", bus.pronto, 1'b1);
    drv(1, 3'b001, 16'h0002, 16'h0003);
    drv(0, 0, 0, 0);
    chk("post_add_exec", bus.executou, 1'b1);
    chk("post_add_res", bus.resultado, 16'h0005);
`else
    // without the multiplier, 101 is illegal with single-cycle latency
    drv(1, 3'b101, 16'h0003, 16'h0004);
    drv(0, 0, 0, 0);
    chk("nomul_exec", bus.executou, 1'b1);
    chk("nomul_erro", bus.erro, 1'b1);
    chk("nomul_res", bus.resultado, 16'h0000);
    chk("nomul_pronto", bus.pronto, 1'b1);
`endif

    // randomized stream with one mid-stream reset
    for (int i = 0; i < 400; i++) begin
      drv($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), rnd_val(), rnd_val());
      if (i == 200) begin
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        bus.inicio = 1'b0;
        @(negedge clk);
        chk("rst_mid_rel_pronto", bus.pronto, 1'b1);
      end
    end
    repeat (20) drv(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
